regfile_scoreboard: RTL and testbench

Parametrised multi-read-port register file with per-register busy scoreboard, the next-generation replacement for the core's 2R1W register bank. Sits between Decode (reads, reservation on issue) and Writeback (write, busy clear). It supplies operand values together with a busy flag so Decode can detect RAW hazards without a separate scoreboard. Register x0 reads as zero, ignores writes and is never busy.

---
 rtl/regfile_scoreboard.sv | 96 +++++++++
 tb/tb_regfile_scoreboard.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_scoreboard.sv
// Multi-read-port register file with per-register busy scoreboard; x0 is hardwired zero and never busy.
// Optional same-cycle write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_scoreboard #(
  parameter int unsigned data_width   = 32,
  parameter int unsigned num_reg      = 32,
  parameter int unsigned num_rd_ports = 2,
  parameter int unsigned idx_width    = $clog2(num_reg)
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 ren,
  input  logic [num_rd_ports*idx_width-1:0]    raddr,
  output logic [num_rd_ports*data_width-1:0]   rdata,
  output logic [num_rd_ports-1:0]              rbusy,
  input  logic                                 wen,
  input  logic [idx_width-1:0]                 waddr,
  input  logic [data_width-1:0]                wdata,
  input  logic                                 rsv_en,
  input  logic [idx_width-1:0]                 rsv_addr,
  output logic [num_reg-1:0]                   busy_vec
);

  logic [data_width-1:0] regs_q [num_reg];
  logic [num_reg-1:0]    busy_q;
  logic [num_reg-1:0]    busy_d;

  // Entry 0 is reset to zero and never written, so it always reads as zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < num_reg; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wen && (waddr != '0)) begin
      regs_q[waddr] <= wdata;
    end
  end

  // Reserve is applied after the write clear so a new producer supersedes a completing one.
  always_comb begin
    busy_d = busy_q;
    if (wen && (waddr != '0)) begin
      busy_d[waddr] = 1'b0;
    end
    if (rsv_en && (rsv_addr != '0)) begin
      busy_d[rsv_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy_vec = busy_q;

  for (genvar p = 0; p < num_rd_ports; p++) begin : g_rd
    logic [idx_width-1:0]  ra;
    logic [data_width-1:0] rd_d;
    logic [data_width-1:0] rd_q;
    logic                  rb_d;
    logic                  rb_q;

    assign ra = raddr[p*idx_width +: idx_width];

    always_comb begin
      rd_d = '0;
      rb_d = 1'b0;
      if (ra != '0) begin
`ifdef REGFILE_BYPASS_EN
        rd_d = (wen && (waddr == ra)) ? wdata : regs_q[ra];
        rb_d = busy_d[ra];
`else
        rd_d = regs_q[ra];
        rb_d = busy_q[ra];
`endif
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rd_q <= '0;
        rb_q <= 1'b0;
      end else if (ren) begin
        rd_q <= rd_d;
        rb_q <= rb_d;
      end
    end

    assign rdata[p*data_width +: data_width] = rd_q;
    assign rbusy[p]                          = rb_q;
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard: table-driven vectors through an expected-result queue,
// plus hand-written reset and wide-configuration sequences.
module tb_regfile_scoreboard;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic         clk;
  logic         rst_n;

  // 4-port, 32x32 instance
  logic         ren;
  logic [19:0]  raddr;
  logic [127:0] rdata;
  logic [3:0]   rbusy;
  logic         wen;
  logic [4:0]   waddr;
  logic [31:0]  wdata;
  logic         rsv_en;
  logic [4:0]   rsv_addr;
  logic [31:0]  busy_vec;

  // 2-port, 16x64 instance
  logic         ren2;
  logic [7:0]   raddr2;
  logic [127:0] rdata2;
  logic [1:0]   rbusy2;
  logic         wen2;
  logic [3:0]   waddr2;
  logic [63:0]  wdata2;
  logic         rsv_en2;
  logic [3:0]   rsv_addr2;
  logic [15:0]  busy_vec2;

  regfile_scoreboard #(
    .data_width   (32),
    .num_reg      (32),
    .num_rd_ports (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ren      (ren),
    .raddr    (raddr),
    .rdata    (rdata),
    .rbusy    (rbusy),
    .wen      (wen),
    .waddr    (waddr),
    .wdata    (wdata),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .busy_vec (busy_vec)
  );

  regfile_scoreboard #(
    .data_width   (64),
    .num_reg      (16),
    .num_rd_ports (2)
  ) dut_w (
    .clk      (clk),
    .rst_n    (rst_n),
    .ren      (ren2),
    .raddr    (raddr2),
    .rdata    (rdata2),
    .rbusy    (rbusy2),
    .wen      (wen2),
    .waddr    (waddr2),
    .wdata    (wdata2),
    .rsv_en   (rsv_en2),
    .rsv_addr (rsv_addr2),
    .busy_vec (busy_vec2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         ren;
    logic [19:0]  raddr;
    logic         wen;
    logic [4:0]   waddr;
    logic [31:0]  wdata;
    logic         rsv_en;
    logic [4:0]   rsv_addr;
    logic [127:0] exp_rdata;
    logic [3:0]   exp_rbusy;
    logic [31:0]  exp_busy;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];
  int   compared   = 0;
  int   mismatched = 0;

  function automatic vec_t mk(input logic r, input logic [4:0] a0, input logic [4:0] a1,
                              input logic [4:0] a2, input logic [4:0] a3,
                              input logic w, input logic [4:0] wa, input logic [31:0] wd,
                              input logic rs, input logic [4:0] rsa,
                              input logic [31:0] d0, input logic [31:0] d1,
                              input logic [31:0] d2, input logic [31:0] d3,
                              input logic [3:0] rb, input logic [31:0] bv);
    vec_t v;
    v.ren       = r;
    v.raddr     = {a3, a2, a1, a0};
    v.wen       = w;
    v.waddr     = wa;
    v.wdata     = wd;
    v.rsv_en    = rs;
    v.rsv_addr  = rsa;
    v.exp_rdata = {d3, d2, d1, d0};
    v.exp_rbusy = rb;
    v.exp_busy  = bv;
    return v;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input vec_t v, input string tag);
    vec_t e;
    ren      = v.ren;
    raddr    = v.raddr;
    wen      = v.wen;
    waddr    = v.waddr;
    wdata    = v.wdata;
    rsv_en   = v.rsv_en;
    rsv_addr = v.rsv_addr;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      chk({tag, " queue"}, 128'd0, 128'd1);
    end else begin
      e = exp_q.pop_front();
      chk({tag, " rdata"}, rdata, e.exp_rdata);
      chk({tag, " rbusy"}, {124'd0, rbusy}, {124'd0, e.exp_rbusy});
      chk({tag, " busy_vec"}, {96'd0, busy_vec}, {96'd0, e.exp_busy});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    ren = 1'b0; raddr = '0; wen = 1'b0; waddr = '0; wdata = '0; rsv_en = 1'b0; rsv_addr = '0;
    ren2 = 1'b0; raddr2 = '0; wen2 = 1'b0; waddr2 = '0; wdata2 = '0; rsv_en2 = 1'b0; rsv_addr2 = '0;

    //        ren a0 a1 a2 a3  wen wa  wdata          rsv ra  d0            d1     d2            d3  rbusy    busy
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 32'h1,        0, 0, 0,            0,     0,            0,  4'b0000, 32'h0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 2, 32'h2,        0, 0, 0,            0,     0,            0,  4'b0000, 32'h0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 3, 32'h3,        0, 0, 0,            0,     0,            0,  4'b0000, 32'h0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 4, 32'h4,        0, 0, 0,            0,     0,            0,  4'b0000, 32'h0));
    tbl.push_back(mk(1, 4, 3, 0, 1, 0, 0, 32'h0,        0, 0, 4,            3,     0,            1,  4'b0000, 32'h0));
    tbl.push_back(mk(0, 1, 2, 3, 4, 0, 0, 32'h0,        0, 0, 4,            3,     0,            1,  4'b0000, 32'h0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 32'h0,        1, 3, 4,            3,     0,            1,  4'b0000, 32'h8));
    tbl.push_back(mk(1, 3, 3, 0, 2, 0, 0, 32'h0,        0, 0, 3,            3,     0,            2,  4'b0011, 32'h8));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 3, 32'h1111,     0, 0, 3,            3,     0,            2,  4'b0011, 32'h0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 3, 32'h1234,     1, 3, 3,            3,     0,            2,  4'b0011, 32'h8));
    tbl.push_back(mk(1, 3, 0, 3, 1, 0, 0, 32'h0,        0, 0, 32'h1234,     0,     32'h1234,     1,  4'b0101, 32'h8));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 32'hFFFFFFFF, 1, 0, 32'h1234,     0,     32'h1234,     1,  4'b0101, 32'h8));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 32'h0,        0, 0, 0,            0,     0,            0,  4'b0000, 32'h8));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 3, 32'hAAAA,     1, 5, 0,            0,     0,            0,  4'b0000, 32'h20));
    tbl.push_back(mk(1, 3, 5, 2, 1, 0, 0, 32'h0,        0, 0, 32'hAAAA,     0,     2,            1,  4'b0010, 32'h20));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 5, 32'hDEADBEEF, 0, 0, 32'hAAAA,     0,     2,            1,  4'b0010, 32'h0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 32'h0,        1, 7, 32'hAAAA,     0,     2,            1,  4'b0010, 32'h80));
    tbl.push_back(mk(1, 5, 7, 5, 0, 0, 0, 32'h0,        0, 0, 32'hDEADBEEF, 0,     32'hDEADBEEF, 0,  4'b0010, 32'h80));

    repeat (2) @(posedge clk);
    #1;
    chk("por rdata", rdata, 128'd0);
    chk("por rbusy", {124'd0, rbusy}, 128'd0);
    chk("por busy_vec", {96'd0, busy_vec}, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i], $sformatf("vec%0d", i));
    end

    // Asynchronous reset in mid-cycle, with a write and reservation pending that must be dropped.
    wen = 1'b1; waddr = 5'd6; wdata = 32'h99; rsv_en = 1'b1; rsv_addr = 5'd8;
    ren = 1'b1; raddr = {4{5'd6}};
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst rdata", rdata, 128'd0);
    chk("arst rbusy", {124'd0, rbusy}, 128'd0);
    chk("arst busy_vec", {96'd0, busy_vec}, 128'd0);
    @(posedge clk);
    #1;
    chk("arst hold busy_vec", {96'd0, busy_vec}, 128'd0);
    @(negedge clk);
    wen = 1'b0; rsv_en = 1'b0;
    rst_n = 1'b1;
    step(mk(1, 5, 6, 8, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 32'h0), "post-reset");

    // Same-cycle write/reserve versus read; expectations depend on the forwarding build.
    step(mk(0, 0, 0, 0, 0, 1, 9, 32'h11, 0, 0, 0, 0, 0, 0, 4'b0000, 32'h0), "byp wr x9");
    step(mk(1, 9, 9, 9, 9, 1, 9, 32'h22, 0, 0,
            BYP ? 32'h22 : 32'h11, BYP ? 32'h22 : 32'h11,
            BYP ? 32'h22 : 32'h11, BYP ? 32'h22 : 32'h11, 4'b0000, 32'h0), "byp rd x9");
    step(mk(1, 9, 9, 0, 9, 0, 0, 0, 0, 0, 32'h22, 32'h22, 0, 32'h22, 4'b0000, 32'h0), "byp rd x9 next");
    step(mk(1, 10, 10, 10, 10, 0, 0, 0, 1, 10, 0, 0, 0, 0,
            BYP ? 4'b1111 : 4'b0000, 32'h400), "byp rsv x10");
    step(mk(1, 10, 10, 10, 10, 1, 10, 32'h77, 0, 0,
            BYP ? 32'h77 : 32'h0, BYP ? 32'h77 : 32'h0,
            BYP ? 32'h77 : 32'h0, BYP ? 32'h77 : 32'h0,
            BYP ? 4'b0000 : 4'b1111, 32'h0), "byp wr x10");
    step(mk(1, 10, 9, 10, 9, 0, 0, 0, 0, 0, 32'h77, 32'h22, 32'h77, 32'h22, 4'b0000, 32'h0), "byp rd x10 next");

    // Wide configuration: 64-bit data, 16 registers.
    ren = 1'b0; wen = 1'b0; rsv_en = 1'b0;
    wen2 = 1'b1; waddr2 = 4'd15; wdata2 = 64'h0123456789ABCDEF;
    rsv_en2 = 1'b1; rsv_addr2 = 4'd14;
    @(posedge clk);
    #1;
    chk("wide busy after rsv x14", {112'd0, busy_vec2}, {112'd0, 16'h4000});
    wen2 = 1'b0; rsv_en2 = 1'b0;
    ren2 = 1'b1; raddr2 = {4'd14, 4'd15};
    @(posedge clk);
    #1;
    chk("wide rdata", rdata2, {64'h0, 64'h0123456789ABCDEF});
    chk("wide rbusy", {126'd0, rbusy2}, {126'd0, 2'b10});
    ren2 = 1'b0; rsv_en2 = 1'b1; rsv_addr2 = 4'd15;
    @(posedge clk);
    #1;
    chk("wide busy after rsv x15", {112'd0, busy_vec2}, {112'd0, 16'hC000});
    chk("wide rdata hold", rdata2, {64'h0, 64'h0123456789ABCDEF});
    rsv_en2 = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
